trigger_capture: RTL and testbench

- Writer side of the 512-sample trigger buffer; it feeds the block that copies the buffer to display memory during blanking.
- Watches the ADC sample stream for a level crossing, then fills a 512-entry sample array.
- When the array is full, it issues a one-cycle read request to the consumer.
- It holds the array frozen until the consumer's ready flag has dropped and returned high, then re-arms.

---
 rtl/trigger_capture_if.sv | 27 ++
 rtl/trigger_capture.sv | 171 +++++++++++++++++
 tb/tb_trigger_capture.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_capture_if.sv
// Bundle between the trigger-capture writer and its surroundings (ADC side, consumer side).
// The slave modport is the capture block; the master modport is whoever drives it.
interface trigger_capture_if #(
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 512
);
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic [DW-1:0] trig_level;
  logic          trig_slope;
  logic          force_trig;
  logic          rom_ready;
  logic          rom_read;
  logic [DW-1:0] data_output [DEPTH];
  logic          busy;
  logic          triggered;

  modport master (
    output sample_valid, sample, trig_level, trig_slope, force_trig, rom_ready,
    input  rom_read, data_output, busy, triggered
  );

  modport slave (
    input  sample_valid, sample, trig_level, trig_slope, force_trig, rom_ready,
    output rom_read, data_output, busy, triggered
  );
endinterface

// File: rtl/trigger_capture.sv
// Trigger-capture writer: waits for a level crossing (or forced trigger) on the ADC stream,
// fills a DEPTH-entry sample array, hands it to the consumer with a one-cycle rom_read pulse
// and keeps it frozen until the consumer's ready flag has dropped and come back high.
// Optional build macro TRIG_PRETRIG_EN keeps PRE_TRIG samples of history ahead of the trigger.
module trigger_capture #(
  parameter int unsigned DW       = 12,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned PRE_TRIG = 128
) (
  input logic               clk,
  input logic               rst,
  trigger_capture_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = AW + 1;
  localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

  if (PRE_TRIG >= DEPTH) begin : g_bad_pretrig
    $error("PRE_TRIG must be less than DEPTH");
  end
  if ((1 << AW) != DEPTH) begin : g_bad_depth
    $error("DEPTH must be a power of two");
  end

  typedef enum logic [2:0] {
    StArm,
    StCapture,
    StHandoff,
    StWaitLow,
    StWaitHigh
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_valid_q, prev_valid_d;
  logic          triggered_q, triggered_d;
  logic          rom_read_q, rom_read_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          rise_hit, fall_hit, level_hit;
  logic          arm_ok, trig_fire, rearm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

`ifdef TRIG_PRETRIG_EN
  localparam int unsigned   FW        = $clog2(PRE_TRIG + 1);
  localparam logic [AW-1:0] StartAddr = AW'(PRE_TRIG);

  logic [DW-1:0] hist_q [PRE_TRIG];
  logic [FW-1:0] fill_q;

  // Triggers only count once a full window of history is available.
  assign arm_ok = (fill_q == FW'(PRE_TRIG));

  // History shift register: index 0 oldest, PRE_TRIG-1 newest; cleared on reset and re-arm.
  always_ff @(posedge clk) begin
    if (rst || rearm) begin
      fill_q <= '0;
      for (int i = 0; i < PRE_TRIG; i++) hist_q[i] <= '0;
    end else if (state_q == StArm && bus.sample_valid) begin
      for (int i = 0; i < PRE_TRIG - 1; i++) hist_q[i] <= hist_q[i+1];
      hist_q[PRE_TRIG-1] <= bus.sample;
      if (!arm_ok) fill_q <= fill_q + 1'b1;
    end
  end
`else
  localparam logic [AW-1:0] StartAddr = '0;

  assign arm_ok = 1'b1;
`endif

  localparam logic [IW-1:0] StartIdx = {1'b0, StartAddr};

  // Trigger detection; comparisons are plain unsigned DW-bit compares against the previous sample.
  always_comb begin
    rise_hit  = prev_valid_q && (prev_q < bus.trig_level) && (bus.sample >= bus.trig_level);
    fall_hit  = prev_valid_q && (prev_q > bus.trig_level) && (bus.sample <= bus.trig_level);
    level_hit = bus.sample_valid && (bus.trig_slope ? fall_hit : rise_hit);
    trig_fire = (state_q == StArm) && arm_ok && (level_hit || bus.force_trig);
    rearm     = (state_q == StWaitHigh) && bus.rom_ready;
    wr_en     = bus.sample_valid && (trig_fire || (state_q == StCapture));
    wr_addr   = (state_q == StArm) ? StartAddr : idx_q[AW-1:0];
  end

  // Next-state and registered-output logic for the capture/handoff sequence.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    triggered_d  = triggered_q;
    rom_read_d   = 1'b0;
    unique case (state_q)
      StArm: begin
        if (bus.sample_valid) begin
          prev_d       = bus.sample;
          prev_valid_d = 1'b1;
        end
        if (trig_fire) begin
          triggered_d = 1'b1;
          idx_d       = StartIdx + IW'(bus.sample_valid);
          // A trigger sample landing on the last slot completes the capture at once.
          state_d     = (bus.sample_valid && StartIdx == LastIdx) ? StHandoff : StCapture;
        end
      end
      StCapture: begin
        if (bus.sample_valid) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LastIdx) state_d = StHandoff;
        end
      end
      StHandoff: begin
        if (bus.rom_ready) begin
          rom_read_d = 1'b1;
          state_d    = StWaitLow;
        end
      end
      StWaitLow: begin
        if (!bus.rom_ready) state_d = StWaitHigh;
      end
      StWaitHigh: begin
        if (bus.rom_ready) begin
          state_d      = StArm;
          triggered_d  = 1'b0;
          prev_valid_d = 1'b0;
          idx_d        = '0;
        end
      end
      default: state_d = StArm;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StArm;
      idx_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      triggered_q  <= 1'b0;
      rom_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      triggered_q  <= triggered_d;
      rom_read_q   <= rom_read_d;
    end
  end

  // Sample array: zeroed on reset (discarding any partial capture), written only while capturing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
`ifdef TRIG_PRETRIG_EN
      if (trig_fire) begin
        for (int i = 0; i < PRE_TRIG; i++) mem_q[i] <= hist_q[i];
      end
`endif
      if (wr_en) mem_q[wr_addr] <= bus.sample;
    end
  end

  assign bus.data_output = mem_q;
  assign bus.rom_read    = rom_read_q;
  assign bus.triggered   = triggered_q;
  assign bus.busy        = (state_q != StArm);
endmodule

// File: tb/tb_trigger_capture.sv
// Bench for trigger_capture: randomized sample streams against a queue-based reference model;
// completed captures go into a scoreboard that a negedge monitor checks on every rom_read.
module tb_trigger_capture;
  localparam int unsigned DW       = 12;
  localparam int unsigned DEPTH    = 512;
  localparam int unsigned PRE_TRIG = 128;

  typedef logic [DEPTH*DW-1:0] flat_t;
  typedef enum int {MArm, MCap, MHand, MLow, MHigh} mphase_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trigger_capture_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  trigger_capture #(.DW(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  flat_t exp_q[$];

  // Reference model state
  mphase_e       m_phase = MArm;
  logic [DW-1:0] m_prev;
  bit            m_pv, m_trig, m_read;
  logic [DW-1:0] m_cap[$];
  logic [DW-1:0] m_hist[$];
  bit            zero_pending = 0;
  bit            mon_en = 0;
  int            captures_done = 0;

  // Consumer behaviour knobs
  int cons_low  = 0;
  int next_low  = 0;
  int hand_low  = 0;

  task automatic finish_capture();
    flat_t f;
    f = '0;
    for (int i = 0; i < DEPTH; i++) f[i*DW +: DW] = m_cap[i];
    exp_q.push_back(f);
    m_phase = MHand;
  endtask

  // Apply the rules to the inputs present at this clock edge.
  task automatic model_step();
    bit hit;
    logic [DW-1:0] s, lvl;
    s   = bus.sample;
    lvl = bus.trig_level;
    m_read = 0;
    if (rst) begin
      m_phase = MArm; m_pv = 0; m_trig = 0;
      m_cap.delete(); m_hist.delete();
      zero_pending = 1;
      return;
    end
    case (m_phase)
      MArm: begin
        hit = bus.force_trig || (bus.sample_valid && m_pv &&
              (bus.trig_slope ? (m_prev > lvl && s <= lvl) : (m_prev < lvl && s >= lvl)));
`ifdef TRIG_PRETRIG_EN
        if (m_hist.size() < PRE_TRIG) hit = 0;
`endif
        if (hit) begin
          m_cap.delete();
`ifdef TRIG_PRETRIG_EN
          m_cap = m_hist;
`endif
          if (bus.sample_valid) m_cap.push_back(s);
          m_trig  = 1;
          m_phase = MCap;
          if (m_cap.size() == DEPTH) finish_capture();
        end
`ifdef TRIG_PRETRIG_EN
        if (bus.sample_valid) begin
          m_hist.push_back(s);
          if (m_hist.size() > PRE_TRIG) void'(m_hist.pop_front());
        end
`endif
        if (bus.sample_valid) begin m_prev = s; m_pv = 1; end
      end
      MCap: begin
        if (bus.sample_valid) begin
          m_cap.push_back(s);
          if (m_cap.size() == DEPTH) finish_capture();
        end
      end
      MHand: if (bus.rom_ready) begin m_read = 1; m_phase = MLow; end
      MLow:  if (!bus.rom_ready) m_phase = MHigh;
      MHigh: if (bus.rom_ready) begin
        m_phase = MArm; m_trig = 0; m_pv = 0; m_hist.delete(); captures_done++;
      end
      default: m_phase = MArm;
    endcase
  endtask

  // One clock: drive inputs, let the edge happen, advance the model.
  task automatic step(input bit r, input bit v, input logic [DW-1:0] s, input bit f);
    bit rdy;
    if (m_phase == MHand && hand_low > 0) begin
      rdy = 0; hand_low--;
    end else begin
      rdy = (cons_low == 0);
      if (cons_low > 0) cons_low--;
    end
    // Consumer sees rom_read this cycle and drops ready from the next one.
    if (m_read) cons_low = (next_low > 0) ? next_low : $urandom_range(1, 4);
    if (m_read) next_low = 0;
    rst = r; bus.sample_valid = v; bus.sample = s; bus.force_trig = f; bus.rom_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // kind: 0 rising ramp, 1 falling ramp, 2 forced flat, 3 random
  task automatic run_capture(input int kind, input int abort_at);
    int n, start, flat_cnt;
    logic [DW-1:0] val, s;
    bit v, f;
    n = 0; flat_cnt = 0; start = captures_done;
    case (kind)
      0: begin val = 12'd2000; bus.trig_level = 12'd2048; bus.trig_slope = 0; end
      1: begin val = 12'd1100; bus.trig_level = 12'd1000; bus.trig_slope = 1; end
      2: begin val = 12'd500;  bus.trig_level = 12'd2048; bus.trig_slope = 0; end
      default: begin
        val = '0; bus.trig_level = DW'($urandom); bus.trig_slope = $urandom_range(0, 1);
      end
    endcase
    while (captures_done == start && n < 6000) begin
      if (abort_at > 0 && m_phase == MCap && m_cap.size() == abort_at) begin
        step(1, 0, '0, 0);
        abort_at = 0;
      end
      v = ($urandom_range(0, 3) != 0);
      f = 0;
      s = val;
      case (kind)
        0: if (v) val = val + 12'd8;
        1: begin
          if (flat_cnt < 10) begin
            s = 12'd1000;
            if (v) flat_cnt++;
          end else if (v) val = val - 12'd4;
        end
        2: f = (n % 50 == 20);
        default: begin
          s = DW'($urandom);
          f = ($urandom_range(0, 199) == 0);
        end
      endcase
      step(0, v, s, f);
      n++;
    end
    if (captures_done == start) begin
      total++; bad++;
      $display("FAIL capture_timeout kind=%0d got=no_rearm want=rearm_within_6000", kind);
    end
  endtask

  // Monitor: per-cycle status checks plus scoreboard pop on each rom_read.
  always @(negedge clk) begin
    flat_t got, want;
    int first;
    if (mon_en) begin
      total++;
      if (bus.busy !== (m_phase != MArm)) begin
        bad++; $display("FAIL busy got=%b want=%b", bus.busy, (m_phase != MArm));
      end
      total++;
      if (bus.triggered !== m_trig) begin
        bad++; $display("FAIL triggered got=%b want=%b", bus.triggered, m_trig);
      end
      total++;
      if (bus.rom_read !== m_read) begin
        bad++; $display("FAIL rom_read got=%b want=%b", bus.rom_read, m_read);
      end
      for (int i = 0; i < DEPTH; i++) got[i*DW +: DW] = bus.data_output[i];
      if (zero_pending) begin
        zero_pending = 0;
        total++;
        if (got !== '0) begin
          bad++; $display("FAIL reset_zero got=nonzero want=all_zero");
        end
      end
      if (bus.rom_read === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL capture_data got=rom_read want=no_pending_capture");
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            first = -1;
            for (int i = DEPTH - 1; i >= 0; i--)
              if (got[i*DW +: DW] !== want[i*DW +: DW]) first = i;
            bad++;
            $display("FAIL capture_data idx=%0d got=%0d want=%0d", first,
                     got[first*DW +: DW], want[first*DW +: DW]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1;
    bus.sample_valid = 0; bus.sample = '0; bus.trig_level = '0;
    bus.trig_slope = 0; bus.force_trig = 0; bus.rom_ready = 1;
    step(1, 0, '0, 0);
    mon_en = 1;
    step(1, 0, '0, 0);
    step(0, 0, '0, 0);

    run_capture(0, 0);
    run_capture(1, 0);
    hand_low = 20;
    next_low = 600;
    run_capture(2, 0);
    run_capture(0, 300);
    for (int k = 0; k < 4; k++) run_capture(3, 0);
    run_capture(3, 200);
    run_capture(0, 0);

    for (int k = 0; k < 5; k++) step(0, 0, '0, 0);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL unread_captures got=%0d want=0", exp_q.size());
    end
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
